// File: rtl/ntt_pkg.sv
// Shared constants, state encoding and writeback payload for the NTT scheduler.
package ntt_pkg;

  localparam int unsigned N          = 512;
  localparam int unsigned LOG_N      = 9;
  localparam int unsigned NUM_BF     = 256;
  localparam int unsigned LAST_LAYER = 8;

  localparam int unsigned ADDR_W  = LOG_N;
  localparam int unsigned LAYER_W = 4;
  localparam int unsigned BF_W    = 8;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  // One delay-line stage: issue strobe plus the operand address pair.
  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] b;
  } wb_t;

endpackage

// File: rtl/ntt_sched_if.sv
// Scheduler control and RAM address bus.
interface ntt_sched_if;
  import ntt_pkg::*;

  logic               start;
  logic               busy;
  logic               done;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr_a;
  logic [ADDR_W-1:0]  rd_addr_b;
  logic [ADDR_W-1:0]  tw_addr;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr_a;
  logic [ADDR_W-1:0]  wr_addr_b;
  logic [LAYER_W-1:0] layer_num;
  logic [BF_W-1:0]    bf_num;

  modport master (
    output start,
    input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
    input  wr_en, wr_addr_a, wr_addr_b, layer_num, bf_num
  );

  modport slave (
    input  start,
    output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
    output wr_en, wr_addr_a, wr_addr_b, layer_num, bf_num
  );

endinterface

// File: rtl/bf_addr.sv
// Butterfly operand address generator for a 512-point in-place NTT.
module bf_addr
  import ntt_pkg::*;
(
  input  logic [LAYER_W-1:0] layer,
  input  logic [BF_W-1:0]    bf,
  output logic [ADDR_W-1:0]  addr_a,
  output logic [ADDR_W-1:0]  addr_b,
  output logic [ADDR_W-1:0]  offset
);

  // Pair index spread by the layer stride, plus the high butterfly bits as offset.
  always_comb begin
    offset = ADDR_W'(bf) >> (LAYER_W'(LAST_LAYER) - layer);
    addr_a = (ADDR_W'({bf, 1'b0}) << layer) + offset;
    addr_b = (ADDR_W'({bf, 1'b1}) << layer) + offset;
  end

endmodule

// File: rtl/ntt_sched.sv
// Layer/butterfly scheduler for a 512-point forward NTT with a fixed-latency writeback.
module ntt_sched
  import ntt_pkg::*;
#(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned BF_LAT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  ntt_sched_if.slave  bus
);

  localparam int unsigned D = RD_LAT + BF_LAT;

  state_t             state_q, state_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [BF_W-1:0]    bf_q, bf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rd_en_q, rd_en_d;

  logic [ADDR_W-1:0]  addr_a, addr_b, offset;
  logic [ADDR_W-1:0]  rd_a, rd_b, tw;
  wb_t                wb_in;
  wb_t                pipe [D];

  // State, counters and registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      layer_q <= '0;
      bf_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      bf_q    <= bf_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_en_q <= rd_en_d;
    end
  end

  // Next state: issue 256 butterflies, drain D cycles, repeat for 9 layers.
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    bf_d    = bf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          layer_d = '0;
          bf_d    = '0;
        end
      end
      RUN: begin
        if (bf_q == BF_W'(NUM_BF - 1)) begin
          state_d = DRAIN;
          cnt_d   = CNT_W'(D);
        end else begin
          bf_d = bf_q + BF_W'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_W'(1)) begin
          if (layer_q == LAYER_W'(LAST_LAYER)) begin
            state_d = FINISH;
          end else begin
            state_d = RUN;
            layer_d = layer_q + LAYER_W'(1);
            bf_d    = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      FINISH: begin
        state_d = IDLE;
        layer_d = '0;
        bf_d    = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control outputs decoded from the upcoming state so they register in step with it.
  always_comb begin
    busy_d  = 1'b0;
    done_d  = 1'b0;
    rd_en_d = 1'b0;
    unique case (state_d)
      RUN:     begin busy_d = 1'b1; rd_en_d = 1'b1; end
      DRAIN:   busy_d = 1'b1;
      FINISH:  done_d = 1'b1;
      default: ;
    endcase
  end

  bf_addr u_bf_addr (
    .layer  (layer_q),
    .bf     (bf_q),
    .addr_a (addr_a),
    .addr_b (addr_b),
    .offset (offset)
  );

  // Read/twiddle addresses are held at zero outside issue cycles.
  always_comb begin
    tw    = ((ADDR_W'(1) << layer_q) - ADDR_W'(1)) + offset;
    rd_a  = rd_en_q ? addr_a : '0;
    rd_b  = rd_en_q ? addr_b : '0;
    wb_in = '{en: rd_en_q, a: rd_a, b: rd_b};
  end

  // Writeback delay line, D stages, free-running across layers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < D; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= wb_in;
      for (int unsigned i = 1; i < D; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr_a = rd_a;
  assign bus.rd_addr_b = rd_b;
  assign bus.tw_addr   = rd_en_q ? tw : '0;
  assign bus.wr_en     = pipe[D-1].en;
  assign bus.wr_addr_a = pipe[D-1].a;
  assign bus.wr_addr_b = pipe[D-1].b;
  assign bus.layer_num = layer_q;
  assign bus.bf_num    = bf_q;

endmodule

// File: tb/tb_ntt_sched.sv
// Randomized self-checking bench for ntt_sched against a cycle-indexed schedule model.
module tb_ntt_sched;

  localparam int RD_LAT   = 1;
  localparam int BF_LAT   = 3;
  localparam int D        = RD_LAT + BF_LAT;
  localparam int PER      = 256 + D;
  localparam int DONE_CYC = 9 * PER + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ntt_sched_if bus ();

  ntt_sched #(.RD_LAT(RD_LAT), .BF_LAT(BF_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int due;
    int a;
    int b;
    int layer;
  } wr_t;

  int  n_tests = 0;
  int  n_fail  = 0;
  wr_t wq[$];
  int  hits[9][512];
  int  rd_cnt, wr_cnt, done_cnt;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference addressing straight from the transform's index arithmetic.
  task automatic model_addr(input int layer, input int bf, output int a, output int b, output int tw);
    int off;
    off = bf / (1 << (8 - layer));
    a   = ((2 * bf) * (1 << layer) + off) % 512;
    b   = ((2 * bf + 1) * (1 << layer) + off) % 512;
    tw  = (1 << layer) - 1 + off;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  int'(bus.busy), 0);
    check({tag, "_done"},  int'(bus.done), 0);
    check({tag, "_rd_en"}, int'(bus.rd_en), 0);
    check({tag, "_wr_en"}, int'(bus.wr_en), 0);
    check({tag, "_rda"},   int'(bus.rd_addr_a), 0);
    check({tag, "_rdb"},   int'(bus.rd_addr_b), 0);
    check({tag, "_tw"},    int'(bus.tw_addr), 0);
    check({tag, "_wra"},   int'(bus.wr_addr_a), 0);
    check({tag, "_wrb"},   int'(bus.wr_addr_b), 0);
    check({tag, "_layer"}, int'(bus.layer_num), 0);
    check({tag, "_bf"},    int'(bus.bf_num), 0);
  endtask

  task automatic idle_gap();
    int n;
    n = $urandom_range(1, 6);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("gap_busy", int'(bus.busy), 0);
      check("gap_rd_en", int'(bus.rd_en), 0);
      check("gap_wr_en", int'(bus.wr_en), 0);
    end
  endtask

  // One pass; hold keeps start high throughout, abort_at>0 asserts reset at that cycle.
  task automatic run_pass(input bit hold, input int abort_at);
    int  pos, layer, w, a, b, tw, good;
    bit  exp_rd, exp_wr, ok;
    wr_t e;
    wq.delete();
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
    for (int l = 0; l < 9; l++)
      for (int i = 0; i < 512; i++) hits[l][i] = 0;
    bus.start = 1'b1;
    for (int t = 1; t <= DONE_CYC + 2; t++) begin
      @(posedge clk); #1;
      exp_rd = 1'b0;
      layer  = 0;
      w      = 0;
      if (t <= 9 * PER) begin
        pos    = t - 1;
        layer  = pos / PER;
        w      = pos % PER;
        exp_rd = (w < 256);
      end
      check("busy", int'(bus.busy), (t <= 9 * PER) ? 1 : 0);
      check("done", int'(bus.done), (t == DONE_CYC) ? 1 : 0);
      check("rd_en", int'(bus.rd_en), int'(exp_rd));
      if (exp_rd) begin
        model_addr(layer, w, a, b, tw);
        check("layer_num", int'(bus.layer_num), layer);
        check("bf_num", int'(bus.bf_num), w);
        check("rd_addr_a", int'(bus.rd_addr_a), a);
        check("rd_addr_b", int'(bus.rd_addr_b), b);
        check("tw_addr", int'(bus.tw_addr), tw);
        if (layer == 0 && w == 5) begin
          check("l0bf5_a", int'(bus.rd_addr_a), 10);
          check("l0bf5_b", int'(bus.rd_addr_b), 11);
          check("l0bf5_tw", int'(bus.tw_addr), 0);
        end
        if (layer == 8 && w == 5) begin
          check("l8bf5_a", int'(bus.rd_addr_a), 5);
          check("l8bf5_b", int'(bus.rd_addr_b), 261);
          check("l8bf5_tw", int'(bus.tw_addr), 260);
        end
        e.due = t + D; e.a = a; e.b = b; e.layer = layer;
        wq.push_back(e);
      end
      exp_wr = (wq.size() > 0) && (wq[0].due == t);
      check("wr_en", int'(bus.wr_en), int'(exp_wr));
      if (exp_wr) begin
        e = wq.pop_front();
        check("wr_addr_a", int'(bus.wr_addr_a), e.a);
        check("wr_addr_b", int'(bus.wr_addr_b), e.b);
        hits[e.layer][int'(bus.wr_addr_a)]++;
        hits[e.layer][int'(bus.wr_addr_b)]++;
      end
      if (bus.rd_en) rd_cnt++;
      if (bus.wr_en) wr_cnt++;
      if (bus.done)  done_cnt++;
      if (t == abort_at) begin
        rst_n = 1'b0;
        bus.start = 1'b0;
        #1;
        check_all_zero("abort");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
          @(posedge clk); #1;
          check("post_abort_rd_en", int'(bus.rd_en), 0);
          check("post_abort_wr_en", int'(bus.wr_en), 0);
          check("post_abort_busy", int'(bus.busy), 0);
        end
        return;
      end
      if (t <= DONE_CYC) bus.start = hold ? 1'b1 : 1'($urandom_range(0, 1));
      else               bus.start = 1'b0;
    end
    check("rd_count", rd_cnt, 2304);
    check("wr_count", wr_cnt, 2304);
    check("done_count", done_cnt, 1);
    check("wq_left", wq.size(), 0);
    good = 0;
    for (int l = 0; l < 9; l++) begin
      ok = 1'b1;
      for (int i = 0; i < 512; i++) if (hits[l][i] != 1) ok = 1'b0;
      if (ok) good++;
    end
    check("layers_covered", good, 9);
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    #1;
    check_all_zero("reset_async");
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    idle_gap();
    run_pass(1'b0, 0);
    idle_gap();
    run_pass(1'b1, 0);
    idle_gap();
    run_pass(1'b0, 1000);
    idle_gap();
    run_pass(1'b0, 0);
    idle_gap();
    run_pass(1'b0, $urandom_range(2, 2300));
    idle_gap();
    run_pass(1'b0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ntt_sched.md
NTT_SCHED -- requirements
Module: ntt_sched

Interface
REQ-001 Parameter RD_LAT, default 1, coefficient/twiddle RAM read latency in cycles (1..4).
REQ-002 Parameter BF_LAT, default 3, butterfly datapath latency in cycles (1..8); D = RD_LAT+BF_LAT.
REQ-003 clk  input  1  single clock, all logic rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  request a full 512-point forward NTT pass.
REQ-006 busy  output  1  pass in progress.
REQ-007 done  output  1  one-cycle pulse: last writeback completed.
REQ-008 rd_en  output  1  butterfly issue strobe: read both operands and the twiddle this cycle.
REQ-009 rd_addr_a, rd_addr_b  output  9 each  operand read addresses.
REQ-010 tw_addr  output  9  twiddle ROM address.
REQ-011 wr_en  output  1  writeback strobe for butterfly results.
REQ-012 wr_addr_a, wr_addr_b  output  9 each  result write addresses.
REQ-013 layer_num  output  4  current layer 0..8; bf_num  output  8  current butterfly 0..255.

Function
REQ-014 The block SHALL use states IDLE, RUN, DRAIN, FINISH.
REQ-015 IDLE: start=1 SHALL transition to RUN with layer_num=0, bf_num=0; start in any other state SHALL be ignored.
REQ-016 RUN: rd_en=1 every cycle; bf_num SHALL increment by 1; at bf_num=255 transition to DRAIN with drain counter loaded to D.
REQ-017 Addresses SHALL be, with offset = bf_num >> (8-layer_num): rd_addr_a = ((bf_num<<1)<<layer_num mod 512)+offset, rd_addr_b = (((bf_num<<1)|1)<<layer_num mod 512)+offset, all 9-bit wrap.
REQ-018 tw_addr SHALL equal (2^layer_num - 1) + offset, range 0..510.
REQ-019 rd_addr_a, rd_addr_b, tw_addr SHALL be combinational from layer_num/bf_num and valid only when rd_en=1.
REQ-020 wr_en, wr_addr_a, wr_addr_b SHALL be rd_en, rd_addr_a, rd_addr_b delayed exactly D cycles through a shift register.
REQ-021 DRAIN: rd_en=0 for exactly D cycles so the last write of a layer precedes the first read of the next (no RAM read-during-write reliance).
REQ-022 DRAIN end with layer_num<8: layer_num increments, bf_num=0, return to RUN; with layer_num=8: go to FINISH.
REQ-023 FINISH: done=1 for one cycle, busy=0, then IDLE; start in FINISH SHALL be ignored.
REQ-024 busy SHALL be 1 in RUN and DRAIN, 0 in IDLE and FINISH.
REQ-025 Per layer: 256 issue cycles + D idle cycles; start accepted at cycle 0 gives first rd_en at cycle 1 and done at cycle 9*(256+D)-(256+D)+256+D+1 = 9*(256+D)+1 (2341 for D=4).
REQ-026 Delay line SHALL not be cleared at layer boundaries; only reset clears it.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, layer_num=0, bf_num=0, busy=0, done=0, rd_en=0, wr_en=0, all delay-line stages cleared; address outputs 0.
REQ-028 Reset mid-pass SHALL abort with no further wr_en pulses after deassertion; next start begins a full pass from layer 0.

Structure
REQ-029 Shared package ntt_pkg SHALL hold N=512, LOG_N=9, NUM_BF=256, LAST_LAYER=8 and the state enumeration.
REQ-030 Address generation SHALL instantiate the existing bf_addr sub-module; tw_addr and delay line are local.

Verification
REQ-031 Reset, start pulse, D=4 -> rd_en first at cycle 1, busy high cycles 1..2340, single done at 2341, exactly 2304 rd_en and 2304 wr_en pulses.
REQ-032 Layer 0, bf_num=5 -> rd_addr_a=10, rd_addr_b=11, tw_addr=0; layer 8, bf_num=5 -> rd_addr_a=5, rd_addr_b=261, tw_addr=260.
REQ-033 Layer boundary -> exactly 4 cycles rd_en=0 between bf 255 of layer k and bf 0 of layer k+1; last wr_en of layer k strictly before that next rd_en.
REQ-034 Every wr_addr pair equals rd_addr pair issued D cycles earlier; each layer's 512 written addresses cover 0..511 exactly once.
REQ-035 start held high through whole pass and during FINISH -> exactly one pass, one done; rst_n asserted at cycle 1000 -> all outputs 0 immediately, no wr_en afterwards until next start.
